iter_step_unit: RTL and testbench

Parametrised successor to the single-bit combinational inverter. It accepts a W-bit word, a step mode and an iteration count through a valid/ready handshake. It applies the selected step function once per clock until the count is exhausted, then holds the result under a valid/ready output handshake. It sits as a standalone sequential datapath element in the generated `top_level` hierarchy.

---
 rtl/iter_step_unit.sv | 98 +++++++++
 tb/tb_iter_step_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/iter_step_unit.sv
// Iterated step-function datapath: accepts a word, applies one of four step
// functions k times (one per clock), then holds the result until consumed.
module iter_step_unit #(
  parameter int W     = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic [1:0]       in_mode,
  input  logic [CNT_W-1:0] in_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [W-1:0]     acc_q;
  logic [CNT_W-1:0] rem_q;
  logic [1:0]       mode_q;
  logic             out_valid_q;

  logic [W-1:0]     step_d;
  logic [W-1:0]     inv_d;

  // One application of the selected step function to the accumulator.
  always_comb begin
    inv_d  = ~acc_q;
    step_d = acc_q;
    case (mode_q)
      2'd0:    step_d = inv_d;
      2'd1:    step_d = {acc_q[W-2:0], acc_q[W-1]};
      2'd2:    step_d = {inv_d[W-2:0], inv_d[W-1]};
      default: step_d = acc_q + W'(1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      rem_q       <= '0;
      mode_q      <= 2'd0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            acc_q  <= in_data;
            mode_q <= in_mode;
            rem_q  <= in_count;
            if (in_count == '0) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          acc_q <= step_d;
          rem_q <= rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          // Result is frozen here until the consumer takes it.
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Gated by rst so nothing appears acceptable while reset is held.
  assign in_ready  = (state_q == IDLE) && rst;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = acc_q;

endmodule

// File: tb/tb_iter_step_unit.sv
// Directed self-checking bench for iter_step_unit (W=8, CNT_W=4).
module tb_iter_step_unit;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [1:0] in_mode;
  logic [3:0] in_count;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;

  int passCount;
  int checkCount;

  iter_step_unit #(.W(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_count  (in_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  task automatic waitReady(input string tag);
    int guard;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput({tag, "_ready_wait"}, in_ready, 1);
  endtask

  // Issues one request with out_ready high and checks latency, busy span,
  // result value and the return to IDLE; inputs are scrambled after acceptance.
  task automatic applyStimulus(input string tag, input logic [7:0] data, input logic [1:0] mode,
                               input logic [3:0] count, input logic [7:0] expData);
    int cycles;
    int busyCycles;
    out_ready = 1'b1;
    waitReady(tag);
    in_valid = 1'b1;
    in_data  = data;
    in_mode  = mode;
    in_count = count;
    @(negedge clk);
    in_valid   = 1'b0;
    in_data    = ~data;
    in_mode    = ~mode;
    in_count   = 4'd0;
    cycles     = 1;
    busyCycles = 0;
    while (out_valid !== 1'b1 && cycles < 40) begin
      if (busy === 1'b1) busyCycles++;
      @(negedge clk);
      cycles++;
    end
    if (busy === 1'b1) busyCycles++;
    checkOutput({tag, "_valid"}, out_valid, 1);
    checkOutput({tag, "_latency"}, cycles, count + 1);
    checkOutput({tag, "_data"}, out_data, expData);
    @(negedge clk);
    checkOutput({tag, "_busy_span"}, busyCycles, count + 1);
    checkOutput({tag, "_idle_ready"}, in_ready, 1);
    checkOutput({tag, "_idle_valid"}, out_valid, 0);
  endtask

  initial begin
    passCount  = 0;
    checkCount = 0;
    rst        = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    in_mode    = 2'd0;
    in_count   = 4'd0;
    out_ready  = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 8'h00);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_in_ready", in_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("release_in_ready", in_ready, 1);

    applyStimulus("m0_5a_k3", 8'h5A, 2'd0, 4'd3, 8'hA5);
    applyStimulus("m0_5a_k2", 8'h5A, 2'd0, 4'd2, 8'h5A);
    applyStimulus("m0_3c_k0", 8'h3C, 2'd0, 4'd0, 8'h3C);
    applyStimulus("m1_81_k1", 8'h81, 2'd1, 4'd1, 8'h03);
    applyStimulus("m1_81_k8", 8'h81, 2'd1, 4'd8, 8'h81);
    applyStimulus("m2_0f_k1", 8'h0F, 2'd2, 4'd1, 8'hE1);
    applyStimulus("m3_fe_k3", 8'hFE, 2'd3, 4'd3, 8'h01);
    applyStimulus("m3_00_k15", 8'h00, 2'd3, 4'd15, 8'h0F);

    // Backpressure: hold the result while pulsing ignored requests
    out_ready = 1'b0;
    waitReady("bp");
    in_valid = 1'b1;
    in_data  = 8'h11;
    in_mode  = 2'd0;
    in_count = 4'd1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("bp_valid", out_valid, 1);
    checkOutput("bp_data", out_data, 8'hEE);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = 8'h77;
      in_count = 4'd0;
      in_mode  = 2'd3;
      @(negedge clk);
      checkOutput("bp_hold_valid", out_valid, 1);
      checkOutput("bp_hold_data", out_data, 8'hEE);
      checkOutput("bp_hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_in_ready", in_ready, 1);
    checkOutput("bp_release_valid", out_valid, 0);
    applyStimulus("after_bp_22_k0", 8'h22, 2'd0, 4'd0, 8'h22);

    // Reset in the middle of a long run
    waitReady("abort");
    in_valid = 1'b1;
    in_data  = 8'h10;
    in_mode  = 2'd3;
    in_count = 4'd10;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("abort_busy_before", busy, 1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_valid", out_valid, 0);
    checkOutput("abort_data", out_data, 8'h00);
    checkOutput("abort_in_ready", in_ready, 0);
    checkOutput("abort_busy", busy, 0);
    @(negedge clk);
    checkOutput("abort_in_ready_held", in_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_release_ready", in_ready, 1);
    applyStimulus("post_abort_10_k2", 8'h10, 2'd3, 4'd2, 8'h12);

    // Reset coinciding with a request: nothing may be loaded
    rst      = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h99;
    in_mode  = 2'd0;
    in_count = 4'd0;
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    checkOutput("rst_wins_busy", busy, 0);
    checkOutput("rst_wins_valid", out_valid, 0);
    checkOutput("rst_wins_data", out_data, 8'h00);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
